// File: rtl/rk8e_xfer.sv
// rk8e_xfer: RK8E-style disk controller moving sectors between PDP-8 memory (data break) and an SD sector store
// Ports: clk, reset (async), clear (sync); instruction/state/ac/uf CPU IOT decode;
//   disk_bus/skip/interrupt back to CPU; data_break_*/db_* memory cycles; sd_* sector command and word streams.
module rk8e_xfer #(
    parameter int         NDRIVES  = 4,
    parameter int         MAXCYL   = 203,
    parameter int         SECWORDS = 256,
    parameter logic [4:0] F1       = 5'b00001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [0:11] instruction,
    input  logic [4:0]  state,
    input  logic [0:11] ac,
    input  logic        uf,
    output logic [0:11] disk_bus,
    output logic        skip,
    output logic        interrupt,
    output logic        data_break_read,
    output logic        data_break_write,
    output logic [0:14] db_addr,
    output logic [0:11] db_wdata,
    input  logic [0:11] db_rdata,
    input  logic        db_ack,
    output logic        sd_start,
    output logic        sd_write,
    output logic [15:0] sd_lba,
    input  logic        sd_done,
    input  logic [0:11] sd_rd_data,
    input  logic        sd_rd_valid,
    output logic        sd_rd_ready,
    output logic [0:11] sd_wr_data,
    output logic        sd_wr_valid,
    input  logic        sd_wr_ready
);
    localparam int WCW = $clog2(SECWORDS + 1);
    typedef enum logic [3:0] {IDLE, CHECK, SDSTART, RD_WAIT, RD_DB, WR_DB, WR_PUSH, SD_WAIT, DONE} fsm_t;
    fsm_t fsm, fsm_n;
    logic [2:0] op;
    logic [2:0] field;
    logic [1:0] drive;
    logic ie, half, cyl_hi;
    logic [0:11] car, dar, word;
    logic [WCW-1:0] wc;
    logic [3:0] wlock;
    logic err5, err7, err10, err11, done;
    logic iot, clr, busy, is_wr, drv_err, cyl_err, wl_err, bad, last, in_brk, in_next;
    logic [2:0] fn;
    logic [7:0] cyl;
    logic [WCW-1:0] lim;
    logic [0:11] status;
    assign iot = state == F1 && !uf && instruction[0:8] == 9'o674;
    assign fn = instruction[9:11];
    assign clr = clear || (iot && fn == 3'd2 && ac[10:11] == 2'b01);
    assign busy = fsm != IDLE;
    assign status = {busy, 4'b0, err5, 1'b0, err7, 2'b0, err10, err11};
    assign cyl = {cyl_hi, dar[0:6]};
    assign is_wr = op[2:1] == 2'b10;
    assign drv_err = int'(drive) >= NDRIVES;
    assign cyl_err = int'(cyl) > MAXCYL;
    assign wl_err = is_wr && wlock[drive];
    // Only reads (0/1) and writes (4/5) touch the SD card; everything else finishes straight from CHECK
    assign bad = drv_err || cyl_err || wl_err || op[1];
    assign lim = half ? WCW'(SECWORDS / 2) : WCW'(SECWORDS);
    assign last = wc == WCW'(SECWORDS - 1);
    assign in_brk = wc < lim;
    assign in_next = (wc + WCW'(1)) < lim;
    assign sd_lba = {1'b0, drive, cyl, dar[7:11]};
    assign db_addr = {field, car};
    assign db_wdata = word;
    assign sd_wr_data = word;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fsm <= IDLE;
        else
            fsm <= clr ? IDLE : fsm_n;
    end
    always_comb begin
        fsm_n = fsm;
        sd_start = 1'b0;
        sd_write = 1'b0;
        sd_rd_ready = 1'b0;
        sd_wr_valid = 1'b0;
        data_break_read = 1'b0;
        data_break_write = 1'b0;
        case (fsm)
            IDLE:    fsm_n = (iot && fn == 3'd3) ? CHECK : IDLE;
            CHECK:   fsm_n = bad ? DONE : SDSTART;
            SDSTART: begin
                sd_start = 1'b1;
                sd_write = is_wr;
                fsm_n = !is_wr ? RD_WAIT : in_brk ? WR_DB : WR_PUSH;
            end
            RD_WAIT: begin
                sd_rd_ready = 1'b1;
                if (sd_rd_valid)
                    fsm_n = in_brk ? RD_DB : last ? SD_WAIT : RD_WAIT;
            end
            RD_DB: begin
                data_break_write = 1'b1;
                if (db_ack)
                    fsm_n = last ? SD_WAIT : RD_WAIT;
            end
            WR_DB: begin
                data_break_read = 1'b1;
                if (db_ack)
                    fsm_n = WR_PUSH;
            end
            WR_PUSH: begin
                sd_wr_valid = 1'b1;
                if (sd_wr_ready)
                    fsm_n = last ? SD_WAIT : in_next ? WR_DB : WR_PUSH;
            end
            SD_WAIT: fsm_n = sd_done ? DONE : SD_WAIT;
            DONE:    fsm_n = IDLE;
            default: fsm_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {op, ie, half, field, drive, cyl_hi} <= '0;
            {car, dar, word, disk_bus} <= '0;
            {err5, err7, err10, err11, done, skip, interrupt} <= '0;
            wlock <= '0;
            wc <= '0;
        end else if (clr) begin
            {op, ie, half, field, drive, cyl_hi} <= '0;
            {car, dar, word, disk_bus} <= '0;
            {err5, err7, err10, err11, done, skip, interrupt} <= '0;
            wlock <= '0;
            wc <= '0;
        end else begin
            interrupt <= done & ie;
            if (state == F1)
                skip <= iot && fn == 3'd1 && done;
            if (iot)
                case (fn)
                    3'd2: {err5, err7, err10, err11, done} <= '0;
                    3'd3: if (busy) err5 <= 1'b1; else dar <= ac;
                    3'd4: car <= ac;
                    3'd5: disk_bus <= status;
                    3'd6: if (busy) err5 <= 1'b1;
                          else begin
                              {op, ie, half} <= ac[0:4];
                              {field, drive, cyl_hi} <= ac[6:11];
                              {err5, err7, err10, err11, done} <= '0;
                          end
                    default: ;
                endcase
            case (fsm)
                CHECK: begin
                    wc <= '0;
                    if (drv_err) err10 <= 1'b1;
                    else if (cyl_err) err11 <= 1'b1;
                    else if (wl_err) err7 <= 1'b1;
                    else if (op == 3'd2) wlock[drive] <= 1'b1;
                    else if (op[2:1] == 2'b11) err10 <= 1'b1;
                end
                // Words past a half-block are still drained from the card but never reach memory
                RD_WAIT: if (sd_rd_valid) begin
                    word <= sd_rd_data;
                    if (!in_brk) wc <= wc + WCW'(1);
                end
                RD_DB: if (db_ack) begin
                    car <= car + 12'd1;
                    wc <= wc + WCW'(1);
                end
                WR_DB: if (db_ack) begin
                    word <= db_rdata;
                    car <= car + 12'd1;
                end
                WR_PUSH: if (sd_wr_ready) begin
                    wc <= wc + WCW'(1);
                    if (!in_next) word <= '0;
                end
                DONE: done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule
